// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared sprite definitions: arbiter FSM states and requester identifiers.
package sprite_rom_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/sprite_rom_arbiter.sv
// Two-requester read arbiter in front of a single sprite RAM with one-cycle read latency.
// Round-robin on ties, with optional locked bursts of up to BURST_MAX beats.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 9,
  parameter int BURST_MAX = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_a_valid,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic              req_a_lock,
  output logic              req_a_ready,
  output logic              rsp_a_valid,
  output logic [DATA_W-1:0] rsp_a_data,
  input  logic              req_b_valid,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic              req_b_lock,
  output logic              req_b_ready,
  output logic              rsp_b_valid,
  output logic [DATA_W-1:0] rsp_b_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d, beat_inc;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q;
  logic              gnt_a, gnt_b, xfer_lock;
  logic              rsp_a_q, rsp_b_q;

  // Grant only ever asserts alongside the matching valid, so grant doubles as ready.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          if (req_a_valid && req_b_valid) begin
            gnt_a = (last_q == REQ_B);
            gnt_b = (last_q == REQ_A);
          end else begin
            gnt_a = req_a_valid;
            gnt_b = req_b_valid;
          end
        end
        LOCK_A:  gnt_a = req_a_valid;
        LOCK_B:  gnt_b = req_b_valid;
        default: ;
      endcase
    end
  end

  assign req_a_ready = gnt_a;
  assign req_b_ready = gnt_b;
  assign mem_addr    = gnt_a ? req_a_addr : (gnt_b ? req_b_addr : addr_q);

  // IDLE and LOCK share one transfer path: the counter is 0 in IDLE, so +1 gives beat 1.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    last_d    = last_q;
    xfer_lock = gnt_a ? req_a_lock : req_b_lock;
    beat_inc  = beat_q + 1'b1;
    if (gnt_a || gnt_b) begin
      last_d = gnt_a ? REQ_A : REQ_B;
      if (xfer_lock && (beat_inc != BURST_LAST)) begin
        state_d = gnt_a ? LOCK_A : LOCK_B;
        beat_d  = beat_inc;
      end else begin
        state_d = IDLE;
        beat_d  = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= REQ_B;
      addr_q  <= '0;
      rsp_a_q <= 1'b0;
      rsp_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      if (gnt_a || gnt_b) addr_q <= mem_addr;
      rsp_a_q <= gnt_a;
      rsp_b_q <= gnt_b;
    end
  end

  assign rsp_a_valid = rsp_a_q;
  assign rsp_b_valid = rsp_b_q;
  assign rsp_a_data  = rsp_a_q ? mem_data : '0;
  assign rsp_b_data  = rsp_b_q ? mem_data : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a one-cycle-latency RAM model.
module tb_sprite_rom_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a_valid, req_a_lock, req_a_ready, rsp_a_valid;
  logic [9:0] req_a_addr;
  logic [8:0] rsp_a_data;
  logic       req_b_valid, req_b_lock, req_b_ready, rsp_b_valid;
  logic [9:0] req_b_addr;
  logic [8:0] rsp_b_data;
  logic [9:0] mem_addr;
  logic [8:0] mem_data;

  int checks;
  int failures;

  sprite_rom_arbiter #(.ADDR_W(10), .DATA_W(9), .BURST_MAX(32)) dut (
    .CLK(clk), .RST(rst),
    .req_a_valid(req_a_valid), .req_a_addr(req_a_addr), .req_a_lock(req_a_lock),
    .req_a_ready(req_a_ready), .rsp_a_valid(rsp_a_valid), .rsp_a_data(rsp_a_data),
    .req_b_valid(req_b_valid), .req_b_addr(req_b_addr), .req_b_lock(req_b_lock),
    .req_b_ready(req_b_ready), .rsp_b_valid(rsp_b_valid), .rsp_b_data(rsp_b_data),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] memf(input logic [9:0] a);
    int x;
    x = int'(a) * 7 + 3;
    return x[8:0];
  endfunction

  always @(posedge clk) mem_data <= memf(mem_addr);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a_valid = 1'b1; req_a_addr = 10'd5; req_a_lock = 1'b0;
    @(negedge clk);
    checks++; if (req_a_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_a got=%0b exp=0", req_a_ready); end
    next_cycle();
    rst = 1'b0; req_a_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_a_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_a_valid got=%0b exp=0", rsp_a_valid); end
    checks++; if (rsp_a_data !== 9'd0) begin failures++; $display("FAIL reset_rsp_a_data got=%0d exp=0", rsp_a_data); end
    checks++; if (rsp_b_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_b_valid got=%0b exp=0", rsp_b_valid); end
    checks++; if (mem_addr !== 10'd0) begin failures++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
    next_cycle();
  endtask

  task automatic test_single();
    req_a_valid = 1'b1; req_a_addr = 10'd5; req_a_lock = 1'b0;
    @(negedge clk);
    checks++; if (req_a_ready !== 1'b1) begin failures++; $display("FAIL single_ready_a got=%0b exp=1", req_a_ready); end
    checks++; if (req_b_ready !== 1'b0) begin failures++; $display("FAIL single_ready_b got=%0b exp=0", req_b_ready); end
    checks++; if (mem_addr !== 10'd5) begin failures++; $display("FAIL single_mem_addr got=%0d exp=5", mem_addr); end
    next_cycle();
    req_a_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_a_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%0b exp=1", rsp_a_valid); end
    checks++; if (rsp_a_data !== memf(10'd5)) begin failures++; $display("FAIL single_rsp_data got=%0d exp=%0d", rsp_a_data, memf(10'd5)); end
    checks++; if (mem_addr !== 10'd5) begin failures++; $display("FAIL single_addr_hold got=%0d exp=5", mem_addr); end
    next_cycle();
    @(negedge clk);
    checks++; if (rsp_a_valid !== 1'b0 || rsp_a_data !== 9'd0) begin failures++; $display("FAIL single_rsp_clear got=%0b/%0d exp=0/0", rsp_a_valid, rsp_a_data); end
    next_cycle();
  endtask

  // Last grant is A after test_single, so the first tie goes to B.
  task automatic test_back_to_back();
    int ia, ib;
    logic exp_a, prev_a;
    logic [9:0] exp_addr, prev_addr;
    ia = 0; ib = 0; exp_a = 1'b0; prev_a = 1'b0; prev_addr = '0;
    req_a_lock = 1'b0; req_b_lock = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req_a_valid = 1'b1; req_b_valid = 1'b1;
      req_a_addr = 10'(100 + ia); req_b_addr = 10'(200 + ib);
      exp_addr = exp_a ? req_a_addr : req_b_addr;
      @(negedge clk);
      checks++; if (req_a_ready !== exp_a) begin failures++; $display("FAIL b2b_ready_a k=%0d got=%0b exp=%0b", k, req_a_ready, exp_a); end
      checks++; if (req_b_ready !== !exp_a) begin failures++; $display("FAIL b2b_ready_b k=%0d got=%0b exp=%0b", k, req_b_ready, !exp_a); end
      checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL b2b_mem_addr k=%0d got=%0d exp=%0d", k, mem_addr, exp_addr); end
      if (k > 0) begin
        checks++; if (rsp_a_valid !== prev_a || rsp_b_valid !== !prev_a) begin failures++; $display("FAIL b2b_rsp_valid k=%0d got=%0b%0b exp=%0b%0b", k, rsp_a_valid, rsp_b_valid, prev_a, !prev_a); end
        checks++; if ((prev_a ? rsp_a_data : rsp_b_data) !== memf(prev_addr)) begin failures++; $display("FAIL b2b_rsp_data k=%0d got=%0d exp=%0d", k, prev_a ? rsp_a_data : rsp_b_data, memf(prev_addr)); end
      end
      prev_a = exp_a; prev_addr = exp_addr;
      next_cycle();
      if (exp_a) ia++; else ib++;
      exp_a = !exp_a;
    end
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_a_valid !== 1'b1 || rsp_a_data !== memf(prev_addr)) begin failures++; $display("FAIL b2b_last_rsp got=%0b/%0d exp=1/%0d", rsp_a_valid, rsp_a_data, memf(prev_addr)); end
    next_cycle();
  endtask

  task automatic test_lock_burst();
    req_b_valid = 1'b1; req_b_addr = 10'd300; req_b_lock = 1'b0;
    @(negedge clk);
    checks++; if (req_b_ready !== 1'b1) begin failures++; $display("FAIL burst_pre_b got=%0b exp=1", req_b_ready); end
    next_cycle();
    req_b_addr = 10'd301; req_a_valid = 1'b1; req_a_lock = 1'b1;
    for (int k = 0; k < 32; k++) begin
      req_a_addr = 10'(k);
      @(negedge clk);
      checks++; if (req_a_ready !== 1'b1 || req_b_ready !== 1'b0) begin failures++; $display("FAIL burst_ready k=%0d got=%0b%0b exp=10", k, req_a_ready, req_b_ready); end
      checks++; if (mem_addr !== 10'(k)) begin failures++; $display("FAIL burst_mem_addr k=%0d got=%0d exp=%0d", k, mem_addr, k); end
      if (k > 0) begin
        checks++; if (rsp_a_valid !== 1'b1 || rsp_a_data !== memf(10'(k - 1))) begin failures++; $display("FAIL burst_rsp k=%0d got=%0b/%0d exp=1/%0d", k, rsp_a_valid, rsp_a_data, memf(10'(k - 1))); end
      end
      next_cycle();
    end
    req_a_lock = 1'b0; req_a_addr = 10'd50;
    @(negedge clk);
    checks++; if (req_b_ready !== 1'b1 || req_a_ready !== 1'b0) begin failures++; $display("FAIL burst_b_after got=%0b%0b exp=01", req_a_ready, req_b_ready); end
    checks++; if (mem_addr !== 10'd301) begin failures++; $display("FAIL burst_b_addr got=%0d exp=301", mem_addr); end
    next_cycle();
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_b_valid !== 1'b1 || rsp_b_data !== memf(10'd301)) begin failures++; $display("FAIL burst_b_rsp got=%0b/%0d exp=1/%0d", rsp_b_valid, rsp_b_data, memf(10'd301)); end
    next_cycle();
  endtask

  // Ends with A still locked at beat count 8.
  task automatic test_forced_release();
    req_a_valid = 1'b1; req_a_lock = 1'b1; req_b_valid = 1'b1; req_b_addr = 10'd400; req_b_lock = 1'b0;
    for (int k = 0; k < 32; k++) begin
      req_a_addr = 10'(500 + k);
      @(negedge clk);
      checks++; if (req_a_ready !== 1'b1 || req_b_ready !== 1'b0) begin failures++; $display("FAIL forced_ready k=%0d got=%0b%0b exp=10", k, req_a_ready, req_b_ready); end
      next_cycle();
    end
    req_a_addr = 10'd532;
    @(negedge clk);
    checks++; if (req_b_ready !== 1'b1 || req_a_ready !== 1'b0) begin failures++; $display("FAIL forced_b_grant got=%0b%0b exp=01", req_a_ready, req_b_ready); end
    checks++; if (mem_addr !== 10'd400) begin failures++; $display("FAIL forced_b_addr got=%0d exp=400", mem_addr); end
    next_cycle();
    req_b_valid = 1'b0;
    for (int k = 32; k < 40; k++) begin
      req_a_addr = 10'(500 + k);
      @(negedge clk);
      checks++; if (req_a_ready !== 1'b1 || mem_addr !== 10'(500 + k)) begin failures++; $display("FAIL forced_resume k=%0d got=%0b/%0d exp=1/%0d", k, req_a_ready, mem_addr, 500 + k); end
      if (k == 32) begin
        checks++; if (rsp_b_valid !== 1'b1 || rsp_b_data !== memf(10'd400)) begin failures++; $display("FAIL forced_b_rsp got=%0b/%0d exp=1/%0d", rsp_b_valid, rsp_b_data, memf(10'd400)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_lock_hold();
    req_a_valid = 1'b0; req_b_valid = 1'b1; req_b_addr = 10'd600; req_b_lock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (req_a_ready !== 1'b0 || req_b_ready !== 1'b0) begin failures++; $display("FAIL hold_ready k=%0d got=%0b%0b exp=00", k, req_a_ready, req_b_ready); end
      checks++; if (mem_addr !== 10'd539) begin failures++; $display("FAIL hold_mem_addr k=%0d got=%0d exp=539", k, mem_addr); end
      checks++; if (rsp_a_valid !== (k == 0)) begin failures++; $display("FAIL hold_rsp_a k=%0d got=%0b exp=%0b", k, rsp_a_valid, k == 0); end
      next_cycle();
    end
    req_a_valid = 1'b1; req_a_lock = 1'b1;
    for (int k = 0; k < 24; k++) begin
      req_a_addr = 10'(700 + k);
      @(negedge clk);
      checks++; if (req_a_ready !== 1'b1 || req_b_ready !== 1'b0) begin failures++; $display("FAIL hold_count k=%0d got=%0b%0b exp=10", k, req_a_ready, req_b_ready); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (req_b_ready !== 1'b1 || req_a_ready !== 1'b0) begin failures++; $display("FAIL hold_release got=%0b%0b exp=01", req_a_ready, req_b_ready); end
    next_cycle();
    req_a_valid = 1'b0; req_b_valid = 1'b0; req_a_lock = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_lock();
    req_b_valid = 1'b1; req_b_lock = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req_b_addr = 10'(800 + k);
      @(negedge clk);
      checks++; if (req_b_ready !== 1'b1) begin failures++; $display("FAIL midrst_b_beat k=%0d got=%0b exp=1", k, req_b_ready); end
      next_cycle();
    end
    rst = 1'b1; req_a_valid = 1'b1; req_a_addr = 10'd900;
    @(negedge clk);
    checks++; if (req_a_ready !== 1'b0 || req_b_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%0b%0b exp=00", req_a_ready, req_b_ready); end
    next_cycle();
    rst = 1'b0; req_a_valid = 1'b0; req_b_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_b_valid !== 1'b0 || rsp_b_data !== 9'd0) begin failures++; $display("FAIL midrst_rsp got=%0b/%0d exp=0/0", rsp_b_valid, rsp_b_data); end
    checks++; if (mem_addr !== 10'd0) begin failures++; $display("FAIL midrst_mem_addr got=%0d exp=0", mem_addr); end
    next_cycle();
    req_a_valid = 1'b1; req_a_addr = 10'd900; req_a_lock = 1'b0;
    req_b_valid = 1'b1; req_b_addr = 10'd901; req_b_lock = 1'b0;
    @(negedge clk);
    checks++; if (req_a_ready !== 1'b1 || req_b_ready !== 1'b0) begin failures++; $display("FAIL midrst_tie got=%0b%0b exp=10", req_a_ready, req_b_ready); end
    checks++; if (mem_addr !== 10'd900) begin failures++; $display("FAIL midrst_tie_addr got=%0d exp=900", mem_addr); end
    next_cycle();
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_a_valid !== 1'b1 || rsp_a_data !== memf(10'd900)) begin failures++; $display("FAIL midrst_rsp_a got=%0b/%0d exp=1/%0d", rsp_a_valid, rsp_a_data, memf(10'd900)); end
    next_cycle();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    req_a_valid = 1'b0; req_a_addr = '0; req_a_lock = 1'b0;
    req_b_valid = 1'b0; req_b_addr = '0; req_b_lock = 1'b0;
    next_cycle();
    next_cycle();
    test_reset();
    test_single();
    test_back_to_back();
    test_lock_burst();
    test_forced_release();
    test_lock_hold();
    test_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
